// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: shared definitions for the accumulator processor control unit.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - opcode values held in IR[15:12]
//   - datapath mux / ALU encodings and the packed control vector
// Optional feature macro: ACC_CTRL_STACK_EN (PUSH/POP stack instructions).
package acc_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StIdle    = 4'd0;
  localparam state_t StFetch   = 4'd1;
  localparam state_t StDecode  = 4'd2;
  localparam state_t StMemAddr = 4'd3;
  localparam state_t StMemRd   = 4'd4;
  localparam state_t StMemWr   = 4'd5;
  localparam state_t StMdrWb   = 4'd6;
  localparam state_t StAluWb   = 4'd7;
  localparam state_t StBranch  = 4'd8;
  localparam state_t StJump    = 4'd9;
  localparam state_t StSpDec   = 4'd10;
  localparam state_t StSpAddr  = 4'd11;
  localparam state_t StPopWb   = 4'd12;
  localparam state_t StHalt    = 4'd13;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OpHalt = 4'd0;
  localparam opcode_t OpLw   = 4'd1;
  localparam opcode_t OpSw   = 4'd2;
  localparam opcode_t OpAdd  = 4'd3;
  localparam opcode_t OpSub  = 4'd4;
  localparam opcode_t OpAnd  = 4'd5;
  localparam opcode_t OpOr   = 4'd6;
  localparam opcode_t OpAddi = 4'd7;
  localparam opcode_t OpLi   = 4'd8;
  localparam opcode_t OpBeq  = 4'd9;
  localparam opcode_t OpBne  = 4'd10;
  localparam opcode_t OpJ    = 4'd11;
  localparam opcode_t OpPush = 4'd12;
  localparam opcode_t OpPop  = 4'd13;

  // ALU operand A select
  localparam logic [1:0] SrcAPc  = 2'd0;
  localparam logic [1:0] SrcAAcc = 2'd1;
  localparam logic [1:0] SrcASp  = 2'd2;

  // ALU operand B select
  localparam logic [2:0] SrcBMdr = 3'd0;
  localparam logic [2:0] SrcBTwo = 3'd1;
  localparam logic [2:0] SrcBSe  = 3'd2;
  localparam logic [2:0] SrcBZe  = 3'd3;
  localparam logic [2:0] SrcBSl1 = 3'd4;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluAnd   = 3'd2;
  localparam logic [2:0] AluOr    = 3'd3;
  localparam logic [2:0] AluPassB = 3'd4;
  localparam logic [2:0] AluPassA = 3'd5;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       bne_or_beq;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       acc_write;
    logic       acc_src;
    logic       sp_write;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CtrlNone = '0;

  // Opcodes that have a defined execution sequence in this build.
  function automatic logic op_is_legal(opcode_t op);
`ifdef ACC_CTRL_STACK_EN
    return op <= OpPop;
`else
    return op <= OpJ;
`endif
  endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// acc_ctrl_decode: combinational decode of (state, latched opcode) into the
// datapath control vector.
//   state_i     : current FSM state
//   opcode_i    : opcode latched at DECODE
//   mem_ready_i : memory handshake (gates the IR/PC load in FETCH)
//   ctrl_o      : every datapath enable / mux select except Illegal
// Optional feature macro: ACC_CTRL_STACK_EN builds the SP_DEC/SP_ADDR/POP_WB decode.
module acc_ctrl_decode
  import acc_ctrl_pkg::*;
(
  input  state_t  state_i,
  input  opcode_t opcode_i,
  input  logic    mem_ready_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = CtrlNone;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b0;
        ctrl_o.src_a    = SrcAPc;
        ctrl_o.src_b    = SrcBTwo;
        ctrl_o.alu_op   = AluAdd;
        // IR and PC only load in the cycle the memory delivers the word.
        if (mem_ready_i) begin
          ctrl_o.ir_write = 1'b1;
          ctrl_o.pc_write = 1'b1;
          ctrl_o.pc_src   = PcSrcAlu;
        end
      end
      StDecode: begin
        // Speculatively compute the branch target into aluOut.
        ctrl_o.src_a  = SrcAPc;
        ctrl_o.src_b  = SrcBSl1;
        ctrl_o.alu_op = AluAdd;
      end
      StMemAddr: begin
        ctrl_o.src_b  = SrcBZe;
        ctrl_o.alu_op = AluPassB;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      StMdrWb: begin
        ctrl_o.acc_write = 1'b1;
        ctrl_o.acc_src   = 1'b1;
      end
      StAluWb: begin
        ctrl_o.src_a     = SrcAAcc;
        ctrl_o.acc_write = 1'b1;
        ctrl_o.acc_src   = 1'b0;
        case (opcode_i)
          OpSub: begin
            ctrl_o.src_b  = SrcBMdr;
            ctrl_o.alu_op = AluSub;
          end
          OpAnd: begin
            ctrl_o.src_b  = SrcBMdr;
            ctrl_o.alu_op = AluAnd;
          end
          OpOr: begin
            ctrl_o.src_b  = SrcBMdr;
            ctrl_o.alu_op = AluOr;
          end
          OpAddi: begin
            ctrl_o.src_b  = SrcBSe;
            ctrl_o.alu_op = AluAdd;
          end
          OpLi: begin
            ctrl_o.src_b  = SrcBZe;
            ctrl_o.alu_op = AluPassB;
          end
          default: begin
            ctrl_o.src_b  = SrcBMdr;
            ctrl_o.alu_op = AluAdd;
          end
        endcase
      end
      StBranch: begin
        ctrl_o.src_a      = SrcAAcc;
        ctrl_o.alu_op     = AluPassA;
        ctrl_o.branch     = 1'b1;
        ctrl_o.pc_src     = PcSrcAluOut;
        // BNE (10) is the only opcode selecting the not-equal sense.
        ctrl_o.bne_or_beq = (opcode_i == OpBne);
      end
      StJump: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PcSrcJump;
      end
`ifdef ACC_CTRL_STACK_EN
      StSpDec: begin
        ctrl_o.src_a    = SrcASp;
        ctrl_o.src_b    = SrcBTwo;
        ctrl_o.alu_op   = AluSub;
        ctrl_o.sp_write = 1'b1;
      end
      StSpAddr: begin
        ctrl_o.src_a  = SrcASp;
        ctrl_o.alu_op = AluPassA;
      end
      StPopWb: begin
        ctrl_o.acc_write = 1'b1;
        ctrl_o.acc_src   = 1'b1;
        ctrl_o.src_a     = SrcASp;
        ctrl_o.src_b     = SrcBTwo;
        ctrl_o.alu_op    = AluAdd;
        ctrl_o.sp_write  = 1'b1;
      end
`endif
      StHalt: begin
        ctrl_o.halted = 1'b1;
      end
      default: begin
        ctrl_o = CtrlNone;
      end
    endcase
  end

endmodule

// File: rtl/accumulator_control.sv
// accumulator_control: multicycle control FSM for the accumulator processor.
// Sequences FETCH/DECODE/execute, waits on MemReady with a timeout, flags HALT
// and illegal opcodes.
//   CLK, reset (async, active-low)
//   Opcode, MemReady                         : inputs
//   PCWrite, Branch, bneOrbeq, PCSrc         : PC control
//   IRWrite, MemRead, MemWrite, IorD         : instruction/memory control
//   AccWrite, AccSrc, SpWrite                : register write control
//   SrcA, SrcB, ALUOP                        : ALU operand/operation select
//   Halted, Illegal                          : status (Illegal is sticky)
// Optional feature macro: ACC_CTRL_STACK_EN enables PUSH (12) / POP (13).
module accumulator_control
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned OPW          = 4,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [OPW-1:0] Opcode,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           Branch,
  output logic           bneOrbeq,
  output logic [1:0]     PCSrc,
  output logic           IRWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IorD,
  output logic           AccWrite,
  output logic           AccSrc,
  output logic           SpWrite,
  output logic [1:0]     SrcA,
  output logic [2:0]     SrcB,
  output logic [2:0]     ALUOP,
  output logic           Halted,
  output logic           Illegal
);

  // Counter only needs to reach MEM_WAIT_MAX-1; the next low cycle times out.
  localparam int unsigned WaitW = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;

  state_t           state_q, state_d;
  opcode_t          opcode_q, opcode_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             illegal_q, illegal_d;

  opcode_t op_in;
  logic    mem_wait_state;
  logic    wait_hit;
  ctrl_t   ctrl;

  assign op_in          = opcode_t'(Opcode);
  assign mem_wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign wait_hit       = !MemReady && (wait_q == WaitW'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch, StMemWr: begin
        if (MemReady) begin
          state_d = (state_q == StFetch) ? StDecode : StFetch;
        end else if (wait_hit) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StDecode: begin
        opcode_d = op_in;
        if (!op_is_legal(op_in)) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          case (op_in)
            OpHalt:                             state_d = StHalt;
            OpLw, OpSw, OpAdd, OpSub, OpAnd, OpOr: state_d = StMemAddr;
            OpAddi, OpLi:                       state_d = StAluWb;
            OpBeq, OpBne:                       state_d = StBranch;
            OpJ:                                state_d = StJump;
`ifdef ACC_CTRL_STACK_EN
            OpPush:                             state_d = StSpDec;
            OpPop:                              state_d = StSpAddr;
`endif
            default: begin
              state_d   = StHalt;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      StMemAddr: state_d = (opcode_q == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (MemReady) begin
          if (opcode_q == OpLw) begin
            state_d = StMdrWb;
`ifdef ACC_CTRL_STACK_EN
          end else if (opcode_q == OpPop) begin
            state_d = StPopWb;
`endif
          end else begin
            state_d = StAluWb;
          end
        end else if (wait_hit) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StMdrWb, StAluWb, StBranch, StJump: state_d = StFetch;
`ifdef ACC_CTRL_STACK_EN
      StSpDec:  state_d = StMemWr;
      StSpAddr: state_d = StMemRd;
      StPopWb:  state_d = StFetch;
`endif
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_wait_state && !MemReady) begin
      wait_d = wait_q + WaitW'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      opcode_q  <= OpHalt;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  acc_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode_q),
    .mem_ready_i (MemReady),
    .ctrl_o      (ctrl)
  );

  assign PCWrite  = ctrl.pc_write;
  assign Branch   = ctrl.branch;
  assign bneOrbeq = ctrl.bne_or_beq;
  assign PCSrc    = ctrl.pc_src;
  assign IRWrite  = ctrl.ir_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IorD     = ctrl.i_or_d;
  assign AccWrite = ctrl.acc_write;
  assign AccSrc   = ctrl.acc_src;
  // Constant 0 without the stack feature: no stack state is built to drive it.
  assign SpWrite  = ctrl.sp_write;
  assign SrcA     = ctrl.src_a;
  assign SrcB     = ctrl.src_b;
  assign ALUOP    = ctrl.alu_op;
  assign Halted   = ctrl.halted;
  assign Illegal  = illegal_q;

endmodule
